// File: rtl/jtframe_lfbuf_sched.sv
// jtframe_lfbuf_sched: external-memory scheduler for the line/frame buffer.
// Copies finished core lines into the write bank and fetches the next display
// line from the opposite bank during each horizontal blank.
// Optional: define JTFRAME_LFBUF_CLR_EN to blank every displayed word by
// writing 16'h0 back to it after it is read.
module jtframe_lfbuf_sched #(
    parameter int HW = 9,
    parameter int VW = 8,
    parameter int LW = 384
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lhbl,
    input  logic             vs,
    input  logic [VW-1:0]    vrender,
    input  logic             ln_done,
    input  logic [VW-1:0]    ln_v,
    output logic             frame,
    output logic [HW-1:0]    fb_addr,
    input  logic [15:0]      fb_din,
    output logic             fb_done,
    output logic [HW-1:0]    rd_addr,
    output logic [15:0]      rd_data,
    output logic             scr_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic [VW+HW:0]   mem_addr,
    output logic [15:0]      mem_wdata,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_ack,
    output logic [1:0]       ovr
);

    localparam logic [HW:0] LW_C = (HW+1)'(LW);

`ifdef JTFRAME_LFBUF_CLR_EN
    typedef enum logic [2:0] {ST_IDLE, ST_WFETCH, ST_WREQ, ST_RREQ, ST_NEXT, ST_RCLR} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_WFETCH, ST_WREQ, ST_RREQ, ST_NEXT} state_t;
`endif

    state_t            state_q, state_d;
    logic              srv_rd_q, srv_rd_d;     // job served by the current word
    logic              rd_rst_q, rd_rst_d;     // read restarted while a word was in flight
    logic              vs_q, lhbl_q;
    logic              frame_q, frame_d;
    logic              wr_pend_q, wr_pend_d;
    logic              rd_pend_q, rd_pend_d;
    logic              wbank_q, wbank_d;
    logic              rbank_q, rbank_d;
    logic [VW-1:0]     wline_q, wline_d;
    logic [VW-1:0]     rline_q, rline_d;
    logic [HW:0]       wc_q, wc_d;
    logic [HW:0]       rc_q, rc_d;
    logic              fb_done_q, fb_done_d;
    logic [HW-1:0]     rd_addr_q, rd_addr_d;
    logic [15:0]       rd_data_q, rd_data_d;
    logic              scr_we_q, scr_we_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [VW+HW:0]    mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic [1:0]        ovr_q, ovr_d;
    logic              lhbl_fall, vs_rise;

    assign lhbl_fall = lhbl_q & ~lhbl;
    assign vs_rise   = vs & ~vs_q;

    assign frame     = frame_q;
    assign fb_addr   = wc_q[HW-1:0];
    assign fb_done   = fb_done_q;
    assign rd_addr   = rd_addr_q;
    assign rd_data   = rd_data_q;
    assign scr_we    = scr_we_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ovr       = ovr_q;

    // State register and all job/bus registers; reset abandons any transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            srv_rd_q    <= 1'b0;
            rd_rst_q    <= 1'b0;
            vs_q        <= 1'b0;
            lhbl_q      <= 1'b0;
            frame_q     <= 1'b0;
            wr_pend_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            wline_q     <= '0;
            rline_q     <= '0;
            wc_q        <= '0;
            rc_q        <= '0;
            fb_done_q   <= 1'b0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
            scr_we_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ovr_q       <= '0;
        end else begin
            state_q     <= state_d;
            srv_rd_q    <= srv_rd_d;
            rd_rst_q    <= rd_rst_d;
            vs_q        <= vs;
            lhbl_q      <= lhbl;
            frame_q     <= frame_d;
            wr_pend_q   <= wr_pend_d;
            rd_pend_q   <= rd_pend_d;
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            wline_q     <= wline_d;
            rline_q     <= rline_d;
            wc_q        <= wc_d;
            rc_q        <= rc_d;
            fb_done_q   <= fb_done_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
            scr_we_q    <= scr_we_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ovr_q       <= ovr_d;
        end
    end

    // Next-state logic: word sequencing first, then job latching, which wins
    always_comb begin
        state_d     = state_q;
        srv_rd_d    = srv_rd_q;
        rd_rst_d    = rd_rst_q;
        frame_d     = frame_q;
        wr_pend_d   = wr_pend_q;
        rd_pend_d   = rd_pend_q;
        wbank_d     = wbank_q;
        rbank_d     = rbank_q;
        wline_d     = wline_q;
        rline_d     = rline_q;
        wc_d        = wc_q;
        rc_d        = rc_q;
        fb_done_d   = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        scr_we_d    = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ovr_d       = ovr_q;

        if (vs_rise) frame_d = ~frame_q;

        case (state_q)
            ST_IDLE: begin
                if (rd_pend_q) begin
                    state_d    = ST_RREQ;
                    srv_rd_d   = 1'b1;
                    rd_rst_d   = 1'b0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {rbank_q, rline_q, rc_q[HW-1:0]};
                end else if (wr_pend_q) begin
                    state_d  = ST_WFETCH;
                    srv_rd_d = 1'b0;
                end
            end
            ST_WFETCH: begin
                // fb_addr has followed wc since before IDLE, so fb_din is settled
                state_d     = ST_WREQ;
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = {wbank_q, wline_q, wc_q[HW-1:0]};
                mem_wdata_d = fb_din;
            end
            ST_WREQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_NEXT;
                end
            end
            ST_RREQ: begin
                if (mem_ack) begin
                    // Screen address comes from the issued request, not rc,
                    // so a restart during the access cannot misplace the word
                    scr_we_d  = 1'b1;
                    rd_data_d = mem_rdata;
                    rd_addr_d = mem_addr_q[HW-1:0];
                    mem_req_d = 1'b0;
`ifdef JTFRAME_LFBUF_CLR_EN
                    state_d     = ST_RCLR;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = '0;
`else
                    state_d   = ST_NEXT;
`endif
                end
            end
`ifdef JTFRAME_LFBUF_CLR_EN
            ST_RCLR: begin
                // One idle clock separates the read ack from the clear request
                if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                end else if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_NEXT;
                end
            end
`endif
            ST_NEXT: begin
                state_d = ST_IDLE;
                if (srv_rd_q) begin
                    if (!rd_rst_q) begin
                        rc_d = rc_q + 1'b1;
                        if (rc_d == LW_C) rd_pend_d = 1'b0;
                    end
                end else begin
                    wc_d = wc_q + 1'b1;
                    if (wc_d == LW_C) begin
                        wr_pend_d = 1'b0;
                        fb_done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (lhbl_fall) begin
            ovr_d[1]  = ovr_q[1] | rd_pend_q;
            rd_rst_d  = rd_pend_q;
            rd_pend_d = 1'b1;
            rline_d   = vrender;
            rbank_d   = ~frame_q;
            rc_d      = '0;
        end

        if (ln_done) begin
            if (wr_pend_q) begin
                ovr_d[0] = 1'b1;
            end else begin
                wr_pend_d = 1'b1;
                wline_d   = ln_v;
                wbank_d   = frame_q;
                wc_d      = '0;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_lfbuf_sched.sv
// Directed bench for jtframe_lfbuf_sched with a 2-clock-latency memory model.
// Honours JTFRAME_LFBUF_CLR_EN when compiled with the same define as the RTL.
module tb_jtframe_lfbuf_sched;

    logic        clk, rst, lhbl, vs, ln_done, mem_ack;
    logic [7:0]  vrender, ln_v;
    logic        frame, fb_done, scr_we, mem_req, mem_we;
    logic [8:0]  fb_addr, rd_addr;
    logic [15:0] fb_din, rd_data, mem_wdata, mem_rdata;
    logic [17:0] mem_addr;
    logic [1:0]  ovr;

    int n_checks = 0;
    int n_fail   = 0;
    int fb_done_cnt = 0;
    int wcnt = 0;
    logic hold_ack = 1'b0;

    logic [34:0] tx_q[$];
    logic [34:0] exp_q[$];
    logic [8:0]  scr_a[$];
    logic [15:0] scr_d[$];

    jtframe_lfbuf_sched #(.HW(9), .VW(8), .LW(384)) dut (
        .clk(clk), .rst(rst), .lhbl(lhbl), .vs(vs), .vrender(vrender),
        .ln_done(ln_done), .ln_v(ln_v), .frame(frame), .fb_addr(fb_addr),
        .fb_din(fb_din), .fb_done(fb_done), .rd_addr(rd_addr), .rd_data(rd_data),
        .scr_we(scr_we), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ovr(ovr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] fbm(input logic [8:0] a);
        logic [15:0] r;
        r = {7'd0, a};
        return (r * 16'd3) ^ 16'hB00F;
    endfunction

    function automatic logic [15:0] rdm(input logic [17:0] a);
        return a[15:0] ^ {a[17:16], 14'h0A5C} ^ 16'h3C00;
    endfunction

    function automatic logic [17:0] mk(input logic b, input logic [7:0] l, input int p);
        return {b, l, 9'(p)};
    endfunction

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        tx_q.delete();
        exp_q.delete();
        scr_a.delete();
        scr_d.delete();
        fb_done_cnt = 0;
    endtask

    task automatic push_wr(input logic b, input logic [7:0] l, input int p);
        exp_q.push_back({1'b1, mk(b, l, p), fbm(9'(p))});
    endtask

    task automatic push_rd(input logic b, input logic [7:0] l, input int p);
        exp_q.push_back({1'b0, mk(b, l, p), 16'h0});
`ifdef JTFRAME_LFBUF_CLR_EN
        exp_q.push_back({1'b1, mk(b, l, p), 16'h0});
`endif
    endtask

    task automatic cmp_tx(input string tag);
        int n;
        check({tag, "_txcount"}, 80'(tx_q.size()), 80'(exp_q.size()));
        n = (tx_q.size() < exp_q.size()) ? tx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_tx%0d", tag, i), 80'(tx_q[i]), 80'(exp_q[i]));
    endtask

    task automatic wait_fb_done(input string tag, input int budget);
        for (int i = 0; i < budget && fb_done_cnt == 0; i++) tick();
        check({tag, "_fbdone_seen"}, 80'(fb_done_cnt != 0), 80'd1);
        repeat (6) tick();
    endtask

    task automatic pulse_ln(input logic [7:0] v);
        ln_v = v;
        ln_done = 1'b1;
        tick();
        ln_done = 1'b0;
    endtask

    function automatic logic [79:0] all_outs();
        return 80'({frame, fb_addr, fb_done, rd_addr, rd_data, scr_we,
                    mem_req, mem_we, mem_addr, mem_wdata, ovr});
    endfunction

    // Memory responder, line-buffer RAM model and output monitors
    initial begin
        forever begin
            @(posedge clk);
            #1;
            fb_din = fbm(fb_addr);
            if (scr_we) begin
                scr_a.push_back(rd_addr);
                scr_d.push_back(rd_data);
            end
            if (fb_done) fb_done_cnt++;
            if (hold_ack) begin
                wcnt = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req) begin
                wcnt++;
                if (wcnt == 2) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdm(mem_addr);
                    tx_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : 16'h0});
                    wcnt = 0;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        int base;
        rst = 1'b1; lhbl = 1'b1; vs = 1'b0; ln_done = 1'b0; ln_v = '0;
        vrender = '0; mem_ack = 1'b0; mem_rdata = '0; fb_din = '0;

        // reset values
        repeat (3) tick();
        check("reset_outs", all_outs(), 80'd0);
        rst = 1'b0;
        repeat (3) tick();
        check("post_reset_outs", all_outs(), 80'd0);

        // plain write job: line 5, bank 0
        clear_logs();
        pulse_ln(8'd5);
        wait_fb_done("wr", 4000);
        for (int i = 0; i < 384; i++) push_wr(1'b0, 8'd5, i);
        cmp_tx("wr");
        check("wr_fbdone_cnt", 80'(fb_done_cnt), 80'd1);
        check("wr_no_scr", 80'(scr_a.size()), 80'd0);
        check("wr_ovr", 80'(ovr), 80'd0);

        // plain read job: line 10 from bank 1
        clear_logs();
        vrender = 8'd10;
        lhbl = 1'b0;
        for (int i = 0; i < 8000 && scr_a.size() < 384; i++) tick();
        repeat (10) tick();
        lhbl = 1'b1;
        for (int i = 0; i < 384; i++) push_rd(1'b1, 8'd10, i);
        cmp_tx("rd");
        check("rd_scr_count", 80'(scr_a.size()), 80'd384);
        for (int i = 0; i < 384 && i < scr_a.size(); i++)
            check($sformatf("rd_scr%0d", i), 80'({scr_a[i], scr_d[i]}),
                  80'({9'(i), rdm(mk(1'b1, 8'd10, i))}));
        check("rd_no_fbdone", 80'(fb_done_cnt), 80'd0);

        // read preempts write after 100 words
        clear_logs();
        pulse_ln(8'd20);
        for (int i = 0; i < 2000 && tx_q.size() < 100; i++) tick();
        vrender = 8'd30;
        lhbl = 1'b0;
        wait_fb_done("pre", 12000);
        lhbl = 1'b1;
        for (int i = 0; i < 100; i++) push_wr(1'b0, 8'd20, i);
        for (int i = 0; i < 384; i++) push_rd(1'b1, 8'd30, i);
        for (int i = 100; i < 384; i++) push_wr(1'b0, 8'd20, i);
        cmp_tx("pre");
        check("pre_fbdone_cnt", 80'(fb_done_cnt), 80'd1);
        check("pre_scr_count", 80'(scr_a.size()), 80'd384);

        // write overrun: second ln_done is dropped
        clear_logs();
        pulse_ln(8'd40);
        for (int i = 0; i < 200 && tx_q.size() < 10; i++) tick();
        pulse_ln(8'd41);
        tick();
        check("wovr_flag", 80'(ovr), 80'd1);
        wait_fb_done("wovr", 4000);
        for (int i = 0; i < 384; i++) push_wr(1'b0, 8'd40, i);
        cmp_tx("wovr");
        check("wovr_fbdone_cnt", 80'(fb_done_cnt), 80'd1);

        // read overrun: restart at word 0 with the new line
        clear_logs();
        vrender = 8'd50;
        lhbl = 1'b0;
        for (int i = 0; i < 2000 && scr_a.size() < 50; i++) tick();
        lhbl = 1'b1;
        tick();
        vrender = 8'd51;
        lhbl = 1'b0;
        tick();
        check("rovr_flag", 80'(ovr), 80'd3);
        for (int i = 0; i < 9000 && !(scr_a.size() > 0 && scr_a[$] == 9'd383); i++) tick();
        repeat (10) tick();
        lhbl = 1'b1;
        check("rovr_scr_enough", 80'(scr_a.size() >= 434), 80'd1);
        for (int i = 0; i < 50 && i < scr_a.size(); i++)
            check($sformatf("rovr_old%0d", i), 80'({scr_a[i], scr_d[i]}),
                  80'({9'(i), rdm(mk(1'b1, 8'd50, i))}));
        base = scr_a.size() - 384;
        for (int i = 0; i < 384 && base >= 0; i++)
            check($sformatf("rovr_new%0d", i), 80'({scr_a[base+i], scr_d[base+i]}),
                  80'({9'(i), rdm(mk(1'b1, 8'd51, i))}));

        // bank swap on vs, then reset with a request outstanding
        clear_logs();
        vs = 1'b1;
        repeat (2) tick();
        vs = 1'b0;
        check("vs_frame", 80'(frame), 80'd1);
        hold_ack = 1'b1;
        pulse_ln(8'd3);
        for (int i = 0; i < 20 && !mem_req; i++) tick();
        check("hold_req_addr", 80'({mem_req, mem_we, mem_addr}),
              80'({1'b1, 1'b1, mk(1'b1, 8'd3, 0)}));
        rst = 1'b1;
        #1;
        check("rst_req_drop", 80'(mem_req), 80'd0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_outs", all_outs(), 80'd0);
        mem_ack = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        mem_ack = 1'b0;
        repeat (12) tick();
        check("late_ack_scr", 80'(scr_a.size()), 80'd0);
        check("late_ack_fbdone", 80'(fb_done_cnt), 80'd0);
        check("late_ack_outs", all_outs(), 80'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jtframe_lfbuf_sched.md
Name: jtframe_lfbuf_sched

Overview:
- Schedules all external-memory traffic of the line/frame buffer.
- Each finished core line is copied from the line buffer into the current write bank of external memory, word by word.
- In each horizontal blank, the next display line is fetched from the opposite bank into the screen buffer.
- Sits between the line-buffer logic and the PSRAM command layer. Exposes a single-word req/ack interface; the PSRAM layer owns bus timing.

Parameters:
- HW, 9, pixel address width; words per line = LW.
- VW, 8, line number width.
- LW, 384, words transferred per line (LW <= 2**HW).

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- lhbl  input  1  horizontal blank, active low
- vs  input  1  vertical sync; the bank is swapped on its rising edge
- vrender  input  VW  line to be displayed next
- ln_done  input  1  pulse: line buffer holds a complete line
- ln_v  input  VW  line number of the completed line, sampled with ln_done
- frame  output  1  current write bank
- fb_addr  output  HW  line-buffer read address for write-back
- fb_din  input  16  line-buffer data, valid 1 clk after fb_addr
- fb_done  output  1  one-clk pulse: write-back finished
- rd_addr  output  HW  screen-buffer write address
- rd_data  output  16  screen-buffer write data
- scr_we  output  1  screen-buffer write strobe
- mem_req  output  1  memory request
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  1+VW+HW  {bank, line, pixel}
- mem_wdata  output  16  write data
- mem_rdata  input  16  read data, valid in the mem_ack cycle
- mem_ack  input  1  one-clk completion pulse
- ovr  output  2  sticky overrun flags: [0] write, [1] read

Behaviour:
- Reset and clock: single clock clk. rst is asynchronous, active-high.
- Reset values: every output is 0, the FSM is in IDLE, and both pending flags are clear. mem_req drops asynchronously. A transaction in flight when rst asserts is abandoned, and a late mem_ack is ignored.
- Bank swap: frame toggles on the clk after the rising edge of vs is detected.
- Job latching: each job latches its bank when it starts, so a swap in mid-job has no effect on that job.
  - Write job: bank = frame.
  - Read job: bank = ~frame.
- Write job: started by ln_done.
  - Latches ln_v and sets wr_pend; the word counter wc = 0.
  - If ln_done arrives while wr_pend is already set: ovr[0] <= 1, and the new request is dropped.
- Read job: started by the falling edge of lhbl.
  - Latches vrender and sets rd_pend; the word counter rc = 0.
  - If the edge arrives while rd_pend is already set: ovr[1] <= 1, and the read restarts at rc = 0 with the new line.
- FSM states: IDLE, WFETCH, WREQ, RREQ, NEXT.
- IDLE:
  - rd_pend -> RREQ.
  - Otherwise wr_pend -> WFETCH.
- WFETCH: fb_addr = wc; wait 1 clk for fb_din, then -> WREQ.
- WREQ:
  - mem_req = 1, mem_we = 1, mem_addr = {wbank, wline, wc}, mem_wdata = fb_din (registered).
  - All request signals stay stable until mem_ack, then -> NEXT.
- RREQ:
  - mem_req = 1, mem_we = 0, mem_addr = {rbank, rline, rc}.
  - On mem_ack: rd_data = mem_rdata, rd_addr = rc, scr_we = 1 for exactly one clk. Then -> NEXT.
- NEXT: increments the counter of the job just served.
  - If that counter reaches LW: clear its pending flag. For a write job, also pulse fb_done for 1 clk.
  - Then -> IDLE.
- Priority and preemption: the read job has priority. A read may preempt a write only at a word boundary; the write resumes later from the saved wc. A request is never withdrawn before its mem_ack.
- Latency: a word costs at least 3 clks plus the memory latency (NEXT and IDLE each take 1 clk).
- Counter widths: wc and rc are HW+1 bits wide. They never wrap past LW.
- Simultaneous ln_done and lhbl fall: both jobs are latched, and the read is served first.

Optional Feature:
- JTFRAME_LFBUF_CLR_EN defined:
  - After each read word is acked, the FSM enters a state RCLR and issues a write of 16'h0 to the same mem_addr.
  - rc advances only after the clear write is acked.
  - The bank just displayed is therefore blank before the core draws into it.
- Not defined: no RCLR state; reads are not followed by writes.

Test Plan:
- Memory acks after 2 clks; ln_done with ln_v=8'd5, frame=0 -> 384 writes at addresses {0,5,0..383} carrying the fb_din values; fb_done pulses once after the 384th ack; no scr_we.
- lhbl falls with vrender=8'd10, frame=0 -> 384 reads from {1,10,n}; scr_we pulses 384 times with rd_addr 0..383 and rd_data equal to the model data.
- ln_done, then lhbl falls after 100 write words -> the read completes all 384 words, then writes resume at wc=100; exactly 384 writes in total and no duplicate addresses.
- A second ln_done before fb_done -> ovr[0]=1 and the first job completes unchanged; a second lhbl fall during a read -> ovr[1]=1 and the read restarts at rd_addr 0.
- rst asserted in WREQ with mem_ack withheld -> mem_req=0 immediately; after release all outputs are 0 and a late mem_ack causes no scr_we or fb_done.
- JTFRAME_LFBUF_CLR_EN defined, one read line -> every read is followed by a write of 0 to the same address; 768 transactions in total.
